dram_mc: RTL
============

Name: dram_mc

Overview:
- Parametrised, synthesizable multi-channel byte-lane memory.
- Successor to the fixed 16-lane DRAM model that sits opposite top_level.
- Per-channel independent read/write ports, configurable access latency, per-channel op select and out-of-range error reporting.
- Used as the backing store for top_level in system sims and as a drop-in memory for FPGA bring-up.

Parameters:
- NUM_CH, 16, number of independent request channels (lanes).
- DATA_W, 8, data width per channel in bits.
- ADDR_W, 64, external address width per channel.
- MEM_AW, 12, implemented storage address bits; DEPTH = 2**MEM_AW words.
- LATENCY, 3, cycles from request acceptance to valid; legal range 1..16.
- NUM_BANKS, 4, bank count; used only with the optional feature; power of 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- en  in  NUM_CH  per-channel request strobe
- rdwr  in  NUM_CH  per-channel op: 0 = read, 1 = write
- addr  in  NUM_CH x ADDR_W  per-channel word address
- data_in  in  NUM_CH x DATA_W  per-channel write data
- ready  out  NUM_CH  channel accepts a request this cycle
- data_out  out  NUM_CH x DATA_W  read data, qualified by valid
- valid  out  NUM_CH  response strobe for reads and writes (write ack)
- err  out  NUM_CH  response had an out-of-range address; qualified by valid

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high.
- Accept: a request on channel i is accepted at posedge when en[i] && ready[i] && !reset.
- Response: an accepted request produces exactly one valid[i] pulse, exactly LATENCY cycles later.
  - Back-to-back accepts give back-to-back valids, in order.
  - Throughput is 1 request per channel per cycle.
- Range check: addr[i][ADDR_W-1:MEM_AW] != 0 marks the request out-of-range.
  - Out-of-range write: memory is not modified.
  - Out-of-range read: data_out = 0.
  - In both cases err[i] = 1 alongside valid[i].
- Read: memory is sampled at the accept edge, and that value is delayed LATENCY cycles.
  - Same-cycle read and write to the same address by different channels: the read returns the old data (read-before-write).
  - A read accepted one cycle after a write returns the new data.
- Write: takes effect at the accept edge. data_out on a write response = 0, err as computed.
- Same-cycle writes from several channels to the same address: the highest channel index wins.
- Outputs when valid[i] = 0: data_out[i] = 0 and err[i] = 0.
- Reset values: valid = 0, err = 0, data_out = 0.
  - ready = all ones, both during and after reset.
  - The in-flight pipeline is cleared. Memory contents are not reset.
- Reset mid-operation: in-flight responses are dropped (no valid is ever issued). Requests presented while reset = 1 are ignored, and writes do not commit.
- en = 0: no state change; the pipeline slot carries valid = 0.
- Without the optional feature, ready is constant all-ones.

Optional Feature:
- Macro: DRAM_MC_BANK_ARB_EN.
- Defined:
  - bank = addr[i][$clog2(NUM_BANKS)-1:0].
  - Per cycle, each bank serves at most one channel, chosen by a fixed lowest-index-wins priority among channels with en = 1.
  - ready[i] is combinational: 0 when a lower-indexed channel with en = 1 targets the same bank.
  - A losing request is not accepted; the requester holds en/addr/data until ready.
  - Out-of-range requests still arbitrate on their bank bits.
  - Latency of accepted requests is unchanged.
- Undefined: no arbitration logic is built, and ready is always all-ones.

Decomposition:
- Package dram_mc_pkg holds:
  - op_e enum (OP_RD = 1'b0, OP_WR = 1'b1);
  - default parameter constants;
  - the resp_t struct {valid, err, data}, declared with a fixed parameter value inside the package.
- Sub-module dram_mc_delay_line:
  - a parametrised LATENCY-stage shift register of resp_t, with synchronous reset of the valid bits;
  - instantiated once per channel.
- Storage is a single behavioural array. The arbiter is inline logic under the macro.

Test Plan:
- Reset: hold reset for 3 cycles, with en = all ones driven during reset. Then drive en = 0 for LATENCY+1 cycles → valid = 0, err = 0, data_out = 0 throughout; ready = 16'hFFFF.
- Write then read: ch0 writes 8'hA5 to addr 0x10. Next cycle ch5 reads 0x10 → ch0 valid at t+3 with err = 0; ch5 valid at t+4 with data_out 8'hA5.
- Same-cycle collision: ch2 and ch9 both write 0x20 (8'h11 and 8'h99) while ch3 reads 0x20, whose old value is 8'h00. Later ch0 reads 0x20 → ch3 returns 8'h00; ch0 returns 8'h99.
- Out-of-range: ch7 writes 8'hFF to addr 64'h1000 (bit 12 set), then reads 64'h1000, then reads 0x000 → both 0x1000 responses have err = 1 and data_out 0 (read); the 0x000 read returns its prior value with err = 0.
- Reset mid-flight: accept reads on all 16 channels, then assert reset 1 cycle later → no valid pulses for those requests at any later cycle.
- With DRAM_MC_BANK_ARB_EN: ch1 and ch4 both request addr 0x05 (bank 1) for 2 cycles → ready[4] = 0 in cycle 1; ch1 is accepted in cycle 1 and ch4 in cycle 2; valids arrive at +3 and +4.

Source files
------------

// File: rtl/dram_mc_pkg.sv
// Shared types and default parameter values for the dram_mc multi-channel memory.
// The response record carries a fixed data width; wider DATA_W values are truncated to it.
package dram_mc_pkg;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int DEF_NUM_CH    = 16;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 64;
  localparam int DEF_MEM_AW    = 12;
  localparam int DEF_LATENCY   = 3;
  localparam int DEF_NUM_BANKS = 4;

  localparam int RESP_DATA_W = DEF_DATA_W;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [RESP_DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/dram_mc_delay_line.sv
// Fixed-latency response pipeline for one channel: LATENCY register stages of resp_t.
// Reset empties every stage so no in-flight response survives it.
module dram_mc_delay_line
  import dram_mc_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic  clk,
  input  logic  reset,
  input  resp_t d,
  output resp_t q
);

  resp_t stage_r [LATENCY];

  // Shift responses one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < LATENCY; s++) begin
        stage_r[s] <= '0;
      end
    end else begin
      stage_r[0] <= d;
      for (int s = 1; s < LATENCY; s++) begin
        stage_r[s] <= stage_r[s-1];
      end
    end
  end

  assign q = stage_r[LATENCY-1];

endmodule

// File: rtl/dram_mc.sv
// Multi-channel byte-lane memory with per-channel fixed-latency responses and range errors.
// Optional per-bank request arbitration is built when DRAM_MC_BANK_ARB_EN is defined.
module dram_mc
  import dram_mc_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_AW    = DEF_MEM_AW,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int NUM_BANKS = DEF_NUM_BANKS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              en,
  input  logic [NUM_CH-1:0]              rdwr,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  addr,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  data_in,
  output logic [NUM_CH-1:0]              ready,
  output logic [NUM_CH-1:0][DATA_W-1:0]  data_out,
  output logic [NUM_CH-1:0]              valid,
  output logic [NUM_CH-1:0]              err
);

  localparam int DEPTH = 2**MEM_AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [NUM_CH-1:0] in_range;
  logic [NUM_CH-1:0] accept;
  resp_t             req_resp [NUM_CH];
  resp_t             rsp      [NUM_CH];

`ifdef DRAM_MC_BANK_ARB_EN
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  // Lowest-index requester wins its bank; out-of-range requests still use their bank bits.
  always_comb begin
    ready = {NUM_CH{1'b1}};
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = 0; j < i; j++) begin
        ready[i] = ready[i] & ~(en[j] && (addr[j][BANK_W-1:0] == addr[i][BANK_W-1:0]));
      end
    end
  end
`else
  // Any legal bank count is at least one, so every channel is always ready.
  assign ready = {NUM_CH{NUM_BANKS > 0}};
`endif

  assign accept = en & ready & {NUM_CH{~reset}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_range
    assign in_range[g] = (addr[g][ADDR_W-1:MEM_AW] == '0);
  end

  // Ascending loop order lets the highest channel win same-address writes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept[i] && in_range[i] && (op_e'(rdwr[i]) == OP_WR)) begin
        mem[addr[i][MEM_AW-1:0]] <= data_in[i];
      end
    end
  end

  // Build the response at the accept edge; reads see pre-write contents.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      req_resp[i] = '0;
      if (accept[i]) begin
        req_resp[i].valid = 1'b1;
        req_resp[i].err   = ~in_range[i];
        req_resp[i].data  = (in_range[i] && (op_e'(rdwr[i]) == OP_RD))
                          ? RESP_DATA_W'(mem[addr[i][MEM_AW-1:0]]) : '0;
      end else begin
        req_resp[i] = '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dram_mc_delay_line #(
      .LATENCY (LATENCY)
    ) u_delay (
      .clk   (clk),
      .reset (reset),
      .d     (req_resp[g]),
      .q     (rsp[g])
    );

    assign valid[g]    = rsp[g].valid;
    assign err[g]      = rsp[g].err;
    assign data_out[g] = DATA_W'(rsp[g].data);
  end

endmodule
